// File: rtl/natalius_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : natalius_pkg
//  Purpose  : Shared constants for the Natalius I/O hub: port-address region
//             codes and the fill-engine state type.
//  Revision : 1.0  initial release
// ============================================================================
package natalius_pkg;

    // Region codes carried on port_addr[7:5]
    localparam logic [2:0] REG_RAM   = 3'b000;
    localparam logic [2:0] REG_COL   = 3'b001;
    localparam logic [2:0] REG_ROW   = 3'b010;
    localparam logic [2:0] REG_COLOR = 3'b011;
    localparam logic [2:0] REG_SRST  = 3'b100;
    localparam logic [2:0] REG_PIX   = 3'b101;
    localparam logic [2:0] REG_CTRL  = 3'b110;
    localparam logic [2:0] REG_IO    = 3'b111;

    // Fill engine states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage
`default_nettype wire

// File: rtl/natalius_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : natalius_cursor
//  Purpose  : Column/row position counter with clamped load and raster-order
//             increment that wraps at the end of each row and of the frame.
//  Revision : 1.0  initial release
// ============================================================================
module natalius_cursor #(
    parameter int COLS  = 40,
    parameter int ROWS  = 30,
    parameter int COL_W = $clog2(COLS),
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load_col,
    input  logic             i_load_row,
    input  logic [7:0]       i_load_val,
    input  logic             i_inc,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_at_end
);

    localparam logic [8:0]       c_col_lim = 9'(COLS);
    localparam logic [8:0]       c_row_lim = 9'(ROWS);
    localparam logic [COL_W-1:0] c_col_max = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] c_row_max = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_col_last;
    logic             w_row_last;
    logic [COL_W-1:0] w_col_load;
    logic [ROW_W-1:0] w_row_load;

    // Out-of-range load values saturate to the last column/row
    assign w_col_load = ({1'b0, i_load_val} >= c_col_lim) ? c_col_max : i_load_val[COL_W-1:0];
    assign w_row_load = ({1'b0, i_load_val} >= c_row_lim) ? c_row_max : i_load_val[ROW_W-1:0];
    assign w_col_last = (r_col == c_col_max);
    assign w_row_last = (r_row == c_row_max);

    // Position update: loads take priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else begin
            if (i_load_col)
                r_col <= w_col_load;
            else if (i_inc)
                r_col <= w_col_last ? '0 : r_col + COL_W'(1);

            if (i_load_row)
                r_row <= w_row_load;
            else if (i_inc && w_col_last)
                r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
        end
    end

    assign o_col    = r_col;
    assign o_row    = r_row;
    assign o_at_end = w_col_last && w_row_last;

endmodule
`default_nettype wire

// File: rtl/natalius_io_hub.sv
`default_nettype none
// ============================================================================
//  Module   : natalius_io_hub
//  Purpose  : Processor port hub: scratch-RAM read path, text-cursor / pixel
//             video writes, synchronised input ports, registered output ports
//             and a software reset flag.
//             Define NATALIUS_IO_HUB_FILL_EN to build in the full-screen fill
//             engine (ctrl bit1).
//  Revision : 1.0  initial release
// ============================================================================
module natalius_io_hub
    import natalius_pkg::*;
#(
    parameter int NUM_OUT = 2,
    parameter int NUM_IN  = 2,
    parameter int COLS    = 40,
    parameter int ROWS    = 30,
    parameter int COLOR_W = 3
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [7:0]                             port_addr,
    input  logic                                   write_e,
    input  logic                                   read_e,
    input  logic [7:0]                             data_out,
    output logic [7:0]                             data_in,
    input  logic [7:0]                             mem_out,
    input  logic [8*NUM_IN-1:0]                    din,
    output logic [8*NUM_OUT-1:0]                   dout,
    output logic                                   soft_rst,
    output logic                                   vid_we,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   vid_addr,
    output logic [COLOR_W-1:0]                     vid_color
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [2:0]             w_region;
    logic                   w_busy;
    logic                   w_col_wr;
    logic                   w_row_wr;
    logic                   w_color_wr;
    logic                   w_pix_wr;
    logic                   w_ctrl_wr;
    logic                   w_srst_wr;
    logic                   w_io_wr;
    logic [COL_W-1:0]       w_col;
    logic [ROW_W-1:0]       w_row;
    logic                   w_cur_end;
    logic                   w_fill_we;
    logic [COL_W-1:0]       w_fill_col;
    logic [ROW_W-1:0]       w_fill_row;
    logic [7:0]             w_io_rd;
    logic                   w_unused;

    logic [COLOR_W-1:0]     r_color;
    logic                   r_autoinc;
    logic                   r_soft_rst;
    logic [8*NUM_OUT-1:0]   r_dout;
    logic [8*NUM_IN-1:0]    r_sync1;
    logic [8*NUM_IN-1:0]    r_sync2;
    logic                   r_vid_we;
    logic [ROW_W+COL_W-1:0] r_vid_addr;
    logic [COLOR_W-1:0]     r_vid_color;

    // read_e has no side effects and the middle address bits are not decoded
    assign w_unused = ^{read_e, port_addr[4:2], w_cur_end};

    // Write strobes; video-side writes are locked out while a fill runs
    assign w_region   = port_addr[7:5];
    assign w_col_wr   = write_e && (w_region == REG_COL)   && !w_busy;
    assign w_row_wr   = write_e && (w_region == REG_ROW)   && !w_busy;
    assign w_color_wr = write_e && (w_region == REG_COLOR) && !w_busy;
    assign w_pix_wr   = write_e && (w_region == REG_PIX)   && !w_busy;
    assign w_ctrl_wr  = write_e && (w_region == REG_CTRL);
    assign w_srst_wr  = write_e && (w_region == REG_SRST);
    assign w_io_wr    = write_e && (w_region == REG_IO);

    natalius_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk        (clk),
        .rst        (rst),
        .i_load_col (w_col_wr),
        .i_load_row (w_row_wr),
        .i_load_val (data_out),
        .i_inc      (w_pix_wr && r_autoinc),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_at_end   (w_cur_end)
    );

`ifdef NATALIUS_IO_HUB_FILL_EN
    fill_state_t r_state;
    logic        w_fill_start;
    logic        w_fill_end;

    assign w_busy       = (r_state == FILL);
    assign w_fill_start = w_ctrl_wr && data_out[1] && !w_busy;
    assign w_fill_we    = w_busy;

    // Fill address walker; cleared to {0,0} when a fill starts
    natalius_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_fill_cursor (
        .clk        (clk),
        .rst        (rst),
        .i_load_col (w_fill_start),
        .i_load_row (w_fill_start),
        .i_load_val (8'd0),
        .i_inc      (w_busy),
        .o_col      (w_fill_col),
        .o_row      (w_fill_row),
        .o_at_end   (w_fill_end)
    );

    // Fill FSM: leaves FILL after the last raster address has been issued
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else if (w_fill_start)
            r_state <= FILL;
        else if (w_busy && w_fill_end)
            r_state <= IDLE;
    end
`else
    assign w_busy     = 1'b0;
    assign w_fill_we  = 1'b0;
    assign w_fill_col = '0;
    assign w_fill_row = '0;
`endif

    // Control registers: colour, autoinc, soft reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_color    <= '0;
            r_autoinc  <= 1'b0;
            r_soft_rst <= 1'b0;
        end else begin
            if (w_color_wr) r_color    <= data_out[COLOR_W-1:0];
            if (w_ctrl_wr)  r_autoinc  <= data_out[0];
            if (w_srst_wr)  r_soft_rst <= data_out[0];
        end
    end

    // Output ports; indices beyond NUM_OUT match no port and are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (w_io_wr && (port_addr[1:0] == 2'(k)))
                    r_dout[8*k +: 8] <= data_out;
            end
        end
    end

    // Two-flop input synchroniser, held clear while soft reset is asserted
    always_ff @(posedge clk) begin
        if (rst || r_soft_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Video write port: fill traffic or a single processor pixel write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vid_we    <= 1'b0;
            r_vid_addr  <= '0;
            r_vid_color <= '0;
        end else if (w_fill_we) begin
            r_vid_we    <= 1'b1;
            r_vid_addr  <= {w_fill_row, w_fill_col};
            r_vid_color <= r_color;
        end else if (w_pix_wr) begin
            r_vid_we    <= 1'b1;
            r_vid_addr  <= {w_row, w_col};
            r_vid_color <= data_out[COLOR_W-1:0];
        end else begin
            r_vid_we    <= 1'b0;
        end
    end

    // Synchronised input port selected by port_addr[1:0]
    always_comb begin
        w_io_rd = 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            if (port_addr[1:0] == 2'(k))
                w_io_rd = r_sync2[8*k +: 8];
        end
    end

    // Processor read mux
    always_comb begin
        data_in = 8'h00;
        case (w_region)
            REG_RAM:   data_in = mem_out;
            REG_COL:   data_in = 8'(w_col);
            REG_ROW:   data_in = 8'(w_row);
            REG_COLOR: data_in = 8'(r_color);
            REG_SRST:  data_in = {7'b0, r_soft_rst};
            REG_PIX:   data_in = 8'h00;
            REG_CTRL:  data_in = {w_busy, 5'b0, 1'b0, r_autoinc};
            REG_IO:    data_in = w_io_rd;
            default:   data_in = 8'h00;
        endcase
    end

    assign dout      = r_dout;
    assign soft_rst  = r_soft_rst;
    assign vid_we    = r_vid_we;
    assign vid_addr  = r_vid_addr;
    assign vid_color = r_vid_color;

endmodule
`default_nettype wire

// File: tb/tb_natalius_io_hub.sv
`default_nettype none
// ============================================================================
//  Module   : tb_natalius_io_hub
//  Purpose  : Directed self-checking bench for natalius_io_hub (default
//             parameters). Fill-engine checks are built when
//             NATALIUS_IO_HUB_FILL_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_natalius_io_hub;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  port_addr;
    logic        write_e;
    logic        read_e;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic [7:0]  mem_out;
    logic [15:0] din;
    logic [15:0] dout;
    logic        soft_rst;
    logic        vid_we;
    logic [10:0] vid_addr;
    logic [2:0]  vid_color;

    int n_checks = 0;
    int n_errors = 0;

    natalius_io_hub dut (
        .clk       (clk),
        .rst       (rst),
        .port_addr (port_addr),
        .write_e   (write_e),
        .read_e    (read_e),
        .data_out  (data_out),
        .data_in   (data_in),
        .mem_out   (mem_out),
        .din       (din),
        .dout      (dout),
        .soft_rst  (soft_rst),
        .vid_we    (vid_we),
        .vid_addr  (vid_addr),
        .vid_color (vid_color)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One-cycle write strobe; returns 1 time unit after the capturing edge
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        port_addr = a;
        data_out  = d;
        write_e   = 1'b1;
        @(posedge clk);
        #1;
        write_e   = 1'b0;
    endtask

    // Combinational read between clock edges
    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        port_addr = a;
        read_e    = 1'b1;
        #1;
        check(tag, data_in, exp);
        read_e    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; port_addr = 8'h00; write_e = 1'b0; read_e = 1'b0;
        data_out = 8'h00; mem_out = 8'h00; din = 16'h0000;
        repeat (2) step();
        rst = 1'b0;

        // Reset state
        check("rst_dout", dout, 16'h0000);
        check("rst_soft_rst", soft_rst, 1'b0);
        check("rst_vid_we", vid_we, 1'b0);
        check("rst_vid_addr", vid_addr, 11'd0);
        check("rst_vid_color", vid_color, 3'd0);
        rd("rst_col", 8'h20, 8'h00);
        rd("rst_ctrl", 8'hC0, 8'h00);

        // RAM pass-through
        mem_out = 8'h5A;
        rd("ram_read", 8'h00, 8'h5A);

        // Cursor + colour + pixel write
        wr(8'h20, 8'd5);
        wr(8'h40, 8'd7);
        wr(8'h60, 8'd3);
        wr(8'hA0, 8'h42);
        check("pix_we", vid_we, 1'b1);
        check("pix_addr", vid_addr, 11'd453);
        check("pix_color", vid_color, 3'd2);
        step();
        check("pix_we_drop", vid_we, 1'b0);
        rd("col_read", 8'h20, 8'd5);
        rd("row_read", 8'h40, 8'd7);
        rd("color_read", 8'h60, 8'd3);
        rd("pix_read", 8'hA0, 8'h00);

        // Clamp
        wr(8'h20, 8'd200);
        rd("col_clamp", 8'h20, 8'd39);
        wr(8'h40, 8'd30);
        rd("row_clamp", 8'h40, 8'd29);

        // Auto-increment with frame wrap and row wrap
        wr(8'hC0, 8'h01);
        rd("ctrl_autoinc", 8'hC0, 8'h01);
        wr(8'hA0, 8'h01);
        check("wrap_pix_addr", vid_addr, 11'd1895);
        rd("wrap_col", 8'h20, 8'd0);
        rd("wrap_row", 8'h40, 8'd0);
        wr(8'h20, 8'd39);
        wr(8'h40, 8'd3);
        wr(8'hA0, 8'h01);
        rd("rowinc_col", 8'h20, 8'd0);
        rd("rowinc_row", 8'h40, 8'd4);
        wr(8'hA0, 8'h01);
        rd("inc_col", 8'h20, 8'd1);
        wr(8'hC0, 8'h00);

        // Output ports
        wr(8'hE0, 8'h11);
        wr(8'hE1, 8'h3C);
        check("dout_write", dout, 16'h3C11);
        wr(8'hE3, 8'hFF);
        check("dout_ignored", dout, 16'h3C11);

        // Input synchroniser latency and out-of-range index
        din = 16'hA577;
        step();
        rd("din_lat1", 8'hE1, 8'h00);
        step();
        step();
        rd("din_port1", 8'hE1, 8'hA5);
        rd("din_port0", 8'hE0, 8'h77);
        rd("din_port3", 8'hE3, 8'h00);

        // Soft reset holds the synchroniser clear
        wr(8'h80, 8'h01);
        check("soft_rst_out", soft_rst, 1'b1);
        rd("soft_rst_read", 8'h80, 8'h01);
        step();
        rd("din_softrst", 8'hE1, 8'h00);
        wr(8'h80, 8'h00);
        check("soft_rst_clear", soft_rst, 1'b0);

`ifdef NATALIUS_IO_HUB_FILL_EN
        begin
            int bad;
            int first_bad;
            wr(8'h20, 8'd2);
            wr(8'h60, 8'd6);
            wr(8'hC0, 8'h02);
            rd("fill_busy", 8'hC0, 8'h80);
            bad = 0;
            first_bad = -1;
            for (int i = 0; i < 1200; i++) begin
                logic [10:0] exp_addr;
                step();
                if (i == 10) begin
                    port_addr = 8'h20; data_out = 8'd9; write_e = 1'b1;
                end else begin
                    write_e = 1'b0;
                end
                exp_addr = 11'(((i / 40) << 6) | (i % 40));
                if (vid_we !== 1'b1 || vid_addr !== exp_addr || vid_color !== 3'd6) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            write_e = 1'b0;
            check("fill_seq_bad", bad, 0);
            step();
            check("fill_done_we", vid_we, 1'b0);
            rd("fill_done_busy", 8'hC0, 8'h00);
            rd("fill_col_locked", 8'h20, 8'd2);

            // Reset in the middle of a fill
            wr(8'hC0, 8'h02);
            repeat (500) step();
            check("fill_mid_we", vid_we, 1'b1);
            rst = 1'b1;
            step();
            check("fill_rst_we", vid_we, 1'b0);
            rst = 1'b0;
            rd("fill_rst_busy", 8'hC0, 8'h00);
            step();
            check("fill_rst_we2", vid_we, 1'b0);
        end
`else
        // Without the fill engine, ctrl bit1 does nothing
        wr(8'hC0, 8'h02);
        rd("nofill_ctrl", 8'hC0, 8'h00);
        step();
        check("nofill_we", vid_we, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
